// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control,
// a pass-through tag and a flush that squashes every in-flight operation.
module pipelined_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Flush,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   InData,
  input  logic [SHAMT_W-1:0] InShamt,
  input  logic [1:0]         InMode,
  input  logic [TAG_W-1:0]   InTag,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   OutData,
  output logic [TAG_W-1:0]   OutTag,
  output logic               OutZero
);

  localparam int BITS_PER_STAGE = (SHAMT_W + STAGES - 1) / STAGES;

  logic [STAGES-1:0]  valid_q, valid_d;
  logic [STAGES:0]    ready;
  logic [WIDTH-1:0]   data_q  [STAGES];
  logic [WIDTH-1:0]   data_d  [STAGES];
  logic [SHAMT_W-1:0] shamt_q [STAGES];
  logic [SHAMT_W-1:0] shamt_d [STAGES];
  logic [1:0]         mode_q  [STAGES];
  logic [1:0]         mode_d  [STAGES];
  logic               sign_q  [STAGES];
  logic               sign_d  [STAGES];
  logic [TAG_W-1:0]   tag_q   [STAGES];
  logic [TAG_W-1:0]   tag_d   [STAGES];

  logic               src_valid [STAGES];
  logic [WIDTH-1:0]   src_data  [STAGES];
  logic [SHAMT_W-1:0] src_shamt [STAGES];
  logic [1:0]         src_mode  [STAGES];
  logic               src_sign  [STAGES];
  logic [TAG_W-1:0]   src_tag   [STAGES];

  // Keeps only the shift-amount bits owned by stage idx, still at their weight.
  function automatic logic [SHAMT_W-1:0] stage_amt(input logic [SHAMT_W-1:0] s,
                                                   input int idx);
    logic [SHAMT_W-1:0] r;
    r = '0;
    for (int b = 0; b < SHAMT_W; b++) begin
      if (b >= idx * BITS_PER_STAGE && b < (idx + 1) * BITS_PER_STAGE) r[b] = s[b];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0]   d,
                                                  input logic [SHAMT_W-1:0] amt,
                                                  input logic [1:0]         mode,
                                                  input logic               sign);
    logic [2*WIDTH-1:0] wide;
    case (mode)
      2'b00:   wide = {{WIDTH{1'b0}}, d << amt};
      2'b01:   wide = {{WIDTH{1'b0}}, d >> amt};
      2'b10:   wide = {{WIDTH{sign}}, d} >> amt;
      default: wide = {d, d} >> amt;
    endcase
    return wide[WIDTH-1:0];
  endfunction

  always_comb begin
    ready = '0;
    ready[STAGES] = OutReady;
    for (int i = STAGES - 1; i >= 0; i--) ready[i] = !valid_q[i] || ready[i+1];
  end

  assign InReady = ready[0] && !Flush && Rst_n;

  always_comb begin
    src_valid[0] = InValid && InReady;
    src_data[0]  = InData;
    src_shamt[0] = InShamt;
    src_mode[0]  = InMode;
    src_sign[0]  = InData[WIDTH-1];
    src_tag[0]   = InTag;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
      src_shamt[i] = shamt_q[i-1];
      src_mode[i]  = mode_q[i-1];
      src_sign[i]  = sign_q[i-1];
      src_tag[i]   = tag_q[i-1];
    end
  end

  // A stage advances only when it is ready; otherwise it holds its op intact.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    tag_d   = tag_q;
    for (int i = 0; i < STAGES; i++) begin
      if (ready[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) begin
          data_d[i]  = shift_step(src_data[i], stage_amt(src_shamt[i], i),
                                  src_mode[i], src_sign[i]);
          shamt_d[i] = src_shamt[i];
          mode_d[i]  = src_mode[i];
          sign_d[i]  = src_sign[i];
          tag_d[i]   = src_tag[i];
        end
      end
    end
    if (Flush) valid_d = '0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      shamt_q <= '{default: '0};
      mode_q  <= '{default: '0};
      sign_q  <= '{default: 1'b0};
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
    end
  end

  assign OutValid = valid_q[STAGES-1];
  assign OutData  = data_q[STAGES-1];
  assign OutTag   = tag_q[STAGES-1];
  assign OutZero  = (data_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Bench for pipelined_shift_unit: directed cases, backpressure, flush, reset,
// and a random sweep across STAGES=1/2/5 against a plain-arithmetic shift model.
module tb_pipelined_shift_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;
  logic [4:0]  InShamt = '0;
  logic [1:0]  InMode = '0;
  logic [4:0]  InTag = '0;
  logic        OutReady = 1'b1;

  logic        InReady, OutValid, OutZero;
  logic [31:0] OutData;
  logic [4:0]  OutTag;
  logic        InReady1, OutValid1, OutZero1;
  logic [31:0] OutData1;
  logic [4:0]  OutTag1;
  logic        InReady5, OutValid5, OutZero5;
  logic [31:0] OutData5;
  logic [4:0]  OutTag5;

  pipelined_shift_unit #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutTag(OutTag),
    .OutZero(OutZero));

  pipelined_shift_unit #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady1),
    .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
    .OutValid(OutValid1), .OutReady(OutReady), .OutData(OutData1), .OutTag(OutTag1),
    .OutZero(OutZero1));

  pipelined_shift_unit #(.WIDTH(32), .STAGES(5), .TAG_W(5)) u_dut5 (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady5),
    .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
    .OutValid(OutValid5), .OutReady(OutReady), .OutData(OutData5), .OutTag(OutTag5),
    .OutZero(OutZero5));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          delivered = 0;
  logic        last_in_fire = 1'b0;
  logic        saw_stall = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data = '0;
  logic [4:0]  hold_tag = '0;

  logic        hv [200];
  logic [31:0] hd [200];
  logic [4:0]  ht [200];

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] m);
    logic signed [31:0] sd;
    sd = d;
    case (m)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return 32'(sd >>> sh);
      default: return (d >> sh) | (d << (32 - sh));
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the STAGES=2 unit: sample at negedge, score, return at posedge+1.
  task automatic cycle();
    exp_t e;
    logic in_fire, out_fire;
    @(negedge Clk);
    in_fire  = InValid && InReady;
    out_fire = OutValid && OutReady;
    if (hold_pending) begin
      check("hold_valid", 64'(OutValid), 64'(1));
      check("hold_data", 64'(OutData), 64'(hold_data));
      check("hold_tag", 64'(OutTag), 64'(hold_tag));
    end
    hold_pending = OutValid && !OutReady && !Flush;
    hold_data = OutData;
    hold_tag  = OutTag;
    if (exp_q.size() == 0) begin
      check("idle_outvalid", 64'(OutValid), 64'(0));
    end else if (out_fire) begin
      e = exp_q.pop_front();
      check("out_data", 64'(OutData), 64'(e.d));
      check("out_tag", 64'(OutTag), 64'(e.t));
      check("out_zero", 64'(OutZero), 64'(e.d == 32'd0));
      delivered++;
    end
    if (Flush) begin
      check("flush_inready", 64'(InReady), 64'(0));
      exp_q.delete();
    end
    if (in_fire) begin
      e.d = ref_shift(InData, int'(InShamt), InMode);
      e.t = InTag;
      exp_q.push_back(e);
    end
    if (InValid && !InReady) saw_stall = 1'b1;
    last_in_fire = in_fire;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_one(input string nm, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] m, input logic [4:0] t, input logic [31:0] exp);
    OutReady = 1'b1;
    InValid = 1'b1; InData = d; InShamt = sh; InMode = m; InTag = t;
    cycle();
    check({nm, "_accept"}, 64'(last_in_fire), 64'(1));
    InValid = 1'b0;
    check({nm, "_early"}, 64'(OutValid), 64'(0));
    cycle();
    check({nm, "_valid"}, 64'(OutValid), 64'(1));
    check({nm, "_data"}, 64'(OutData), 64'(exp));
    check({nm, "_tag"}, 64'(OutTag), 64'(t));
    check({nm, "_zero"}, 64'(OutZero), 64'(exp == 32'd0));
    cycle();
  endtask

  task automatic lane(input string nm, input int s, input int c, input logic ov,
                      input logic [31:0] od, input logic [4:0] ot, input logic oz);
    if (c >= s && hv[c-s]) begin
      check({nm, "_valid"}, 64'(ov), 64'(1));
      check({nm, "_data"}, 64'(od), 64'(hd[c-s]));
      check({nm, "_tag"}, 64'(ot), 64'(ht[c-s]));
      check({nm, "_zero"}, 64'(oz), 64'(hd[c-s] == 32'd0));
    end else begin
      check({nm, "_idle"}, 64'(ov), 64'(0));
    end
  endtask

  task automatic pulse_reset();
    InValid = 1'b0;
    #3;
    Rst_n = 1'b0;
    #1;
    check("rst_outvalid", 64'(OutValid), 64'(0));
    check("rst_outzero", 64'(OutZero), 64'(1));
    check("rst_outdata", 64'(OutData), 64'(0));
    check("rst_outtag", 64'(OutTag), 64'(0));
    check("rst_inready", 64'(InReady), 64'(0));
    exp_q.delete();
    hold_pending = 1'b0;
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sd [6];
    logic [4:0]  ssh [6];
    logic [1:0]  sm [6];
    int issued, base;

    @(posedge Clk);
    #2;
    check("init_outvalid", 64'(OutValid), 64'(0));
    check("init_outdata", 64'(OutData), 64'(0));
    check("init_outtag", 64'(OutTag), 64'(0));
    check("init_outzero", 64'(OutZero), 64'(1));
    check("init_inready", 64'(InReady), 64'(0));
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    run_one("sll2", 32'h0000_0001, 5'd2, 2'd0, 5'd3, 32'h0000_0004);
    run_one("sra4", 32'h8000_0000, 5'd4, 2'd2, 5'd4, 32'hF800_0000);
    run_one("srl4", 32'h8000_0000, 5'd4, 2'd1, 5'd5, 32'h0800_0000);
    run_one("ror8", 32'h1234_5678, 5'd8, 2'd3, 5'd6, 32'h7812_3456);
    run_one("sll31", 32'h0000_0001, 5'd31, 2'd0, 5'd7, 32'h8000_0000);
    run_one("ror31", 32'h0000_0001, 5'd31, 2'd3, 5'd8, 32'h0000_0002);
    run_one("sra31n", 32'h8000_0000, 5'd31, 2'd2, 5'd9, 32'hFFFF_FFFF);
    run_one("sra31p", 32'h7000_0000, 5'd31, 2'd2, 5'd10, 32'h0000_0000);
    run_one("srlzero", 32'h0000_000F, 5'd4, 2'd1, 5'd11, 32'h0000_0000);
    for (int m = 0; m < 4; m++)
      run_one("sh0", 32'hA5A5_0F0F, 5'd0, 2'(m), 5'(12 + m), 32'hA5A5_0F0F);

    // Back-to-back stream with a three-cycle consumer stall.
    for (int i = 0; i < 6; i++) begin
      sd[i] = $urandom; ssh[i] = 5'($urandom_range(0, 31)); sm[i] = 2'($urandom_range(0, 3));
    end
    issued = 0; saw_stall = 1'b0; base = delivered;
    for (int k = 0; k < 40 && issued < 6; k++) begin
      OutReady = !(k >= 2 && k <= 4);
      InValid = 1'b1; InData = sd[issued]; InShamt = ssh[issued];
      InMode = sm[issued]; InTag = 5'(20 + issued);
      cycle();
      if (last_in_fire) issued++;
    end
    check("stream_issued", 64'(issued), 64'(6));
    InValid = 1'b0; OutReady = 1'b1;
    drain(20);
    check("stream_delivered", 64'(delivered - base), 64'(6));
    check("stream_stall_seen", 64'(saw_stall), 64'(1));

    // Flush with two ops held in the pipe and a third presented.
    OutReady = 1'b0;
    InValid = 1'b1; InData = 32'h0000_00F0; InShamt = 5'd1; InMode = 2'd0; InTag = 5'd1;
    cycle();
    InData = 32'h0000_0F00; InTag = 5'd2;
    cycle();
    check("preflush_outvalid", 64'(OutValid), 64'(1));
    Flush = 1'b1; InData = 32'h0000_F000; InTag = 5'd3;
    cycle();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    check("postflush_outvalid", 64'(OutValid), 64'(0));
    for (int k = 0; k < 3; k++) cycle();
    run_one("afterflush", 32'h0000_0003, 5'd3, 2'd0, 5'd17, 32'h0000_0018);

    // Asynchronous reset in the middle of a stalled stream.
    OutReady = 1'b0;
    InValid = 1'b1; InData = 32'hDEAD_BEEF; InShamt = 5'd5; InMode = 2'd3; InTag = 5'd4;
    cycle();
    cycle();
    pulse_reset();
    run_one("afterrst", 32'hF000_0000, 5'd28, 2'd1, 5'd18, 32'h0000_000F);

    // Random traffic with backpressure and occasional flush on the STAGES=2 unit.
    for (int k = 0; k < 300; k++) begin
      OutReady = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 23) == 0);
      InValid = ($urandom_range(0, 2) != 0);
      InData = $urandom; InShamt = 5'($urandom_range(0, 31));
      InMode = 2'($urandom_range(0, 3)); InTag = 5'($urandom_range(0, 31));
      cycle();
    end
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    drain(10);

    // Latency and bit-exactness sweep across STAGES=1, 2 and 5.
    pulse_reset();
    OutReady = 1'b1; Flush = 1'b0;
    for (int c = 0; c < 200; c++) begin
      InValid = ($urandom_range(0, 3) != 0);
      InData = $urandom; InShamt = 5'($urandom_range(0, 31));
      InMode = 2'($urandom_range(0, 3)); InTag = 5'($urandom_range(0, 31));
      @(negedge Clk);
      hv[c] = InValid;
      hd[c] = ref_shift(InData, int'(InShamt), InMode);
      ht[c] = InTag;
      check("sweep_inready", 64'({InReady, InReady1, InReady5}), 64'(3'b111));
      lane("s2", 2, c, OutValid, OutData, OutTag, OutZero);
      lane("s1", 1, c, OutValid1, OutData1, OutTag1, OutZero1);
      lane("s5", 5, c, OutValid5, OutData5, OutTag5, OutZero5);
      @(posedge Clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
